// File: rtl/xls_test_result_sink_if.sv
// Handshake bundle between the xls_test operand source/pipeline and the result sink.
interface xls_test_result_sink_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_issue;
  logic             in_ready;
  logic [WIDTH-1:0] pipe_out;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_issue, pipe_out, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_issue, pipe_out, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/xls_test_result_sink.sv
// Captures tagged xls_test pipeline results into a show-ahead FIFO with credit-based issue control.
// Optional popped-value accumulator enabled by XLS_TEST_RESULT_SINK_ACCUM_EN.
module xls_test_result_sink #(
  parameter int unsigned PIPE_LATENCY = 4,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned WIDTH        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  xls_test_result_sink_if.slave bus,
  output logic                  err
`ifdef XLS_TEST_RESULT_SINK_ACCUM_EN
  ,
  input  logic                  acc_clear,
  output logic [WIDTH-1:0]      acc_out
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(PIPE_LATENCY + 1);
  localparam int unsigned SW = $clog2(DEPTH + PIPE_LATENCY + 1);

  logic [PIPE_LATENCY-1:0] delay_q, delay_d;
  logic [IW-1:0]           inflight_q, inflight_d;
  logic [CW-1:0]           count_q, count_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic                    err_q, err_d;
  logic [WIDTH-1:0]        mem_q [DEPTH];

  logic [SW-1:0]           occ;
  logic                    in_ready_w;
  logic                    issue_acc;
  logic                    push;
  logic                    pop;

  // Credit reserves a FIFO slot for every tagged result still in the pipe,
  // so a push can never land on a full FIFO.
  always_comb begin
    occ        = SW'(count_q) + SW'(inflight_q);
    in_ready_w = occ < SW'(DEPTH);
    issue_acc  = bus.in_issue && in_ready_w;
    push       = delay_q[PIPE_LATENCY-1];
    pop        = (count_q != '0) && bus.out_ready;
  end

  always_comb begin
    delay_d    = '0;
    delay_d[0] = issue_acc;
    for (int unsigned i = 1; i < PIPE_LATENCY; i++) begin
      delay_d[i] = delay_q[i-1];
    end

    inflight_d = inflight_q;
    case ({issue_acc, push})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    err_d    = err_q | (bus.in_issue & ~in_ready_w);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      delay_q    <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      delay_q    <= delay_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= bus.pipe_out;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign err           = err_q;

`ifdef XLS_TEST_RESULT_SINK_ACCUM_EN
  logic [WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (pop) begin
      acc_d = acc_clear ? bus.out_data : acc_q + bus.out_data;
    end else if (acc_clear) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_out = acc_q;
`endif

endmodule

// File: tb/tb_xls_test_result_sink.sv
// Randomized self-checking bench: emulates the xls_test pipeline and compares the sink against a queue-based model.
module tb_xls_test_result_sink;
  localparam int unsigned PL    = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned W     = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic err;
  logic [W-1:0] x, y, z, a, c;
  logic [W-1:0] st [PL];
`ifdef XLS_TEST_RESULT_SINK_ACCUM_EN
  logic         acc_clear;
  logic [W-1:0] acc_out;
  logic [W-1:0] m_acc;
`endif

  xls_test_result_sink_if #(.WIDTH(W)) bus ();

  xls_test_result_sink #(
    .PIPE_LATENCY(PL),
    .DEPTH       (DEPTH),
    .WIDTH       (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .err   (err)
`ifdef XLS_TEST_RESULT_SINK_ACCUM_EN
    ,
    .acc_clear (acc_clear),
    .acc_out   (acc_out)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in for the unresettable 4-stage xls_test adder.
  always @(posedge clk) begin
    st[0] <= x + y + z + a + c;
    for (int i = 1; i < int'(PL); i++) st[i] <= st[i-1];
  end
  assign bus.pipe_out = st[PL-1];

  typedef struct {
    int unsigned  due;
    logic [W-1:0] val;
  } pend_t;

  pend_t        pend_q[$];
  logic [W-1:0] fifo_q[$];
  logic         m_err;
  int unsigned  cyc;
  int           n_checks;
  int           n_errors;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Check current outputs against the model, advance the model, then clock once.
  task automatic step();
    logic         exp_ready;
    logic [W-1:0] hd;
    pend_t        p;
    exp_ready = (fifo_q.size() + pend_q.size()) < DEPTH;
    hd = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    chk("in_ready", W'(bus.in_ready), W'(exp_ready));
    chk("out_valid", W'(bus.out_valid), W'(fifo_q.size() != 0));
    chk("out_data", bus.out_data, hd);
    chk("err", W'(err), W'(m_err));
`ifdef XLS_TEST_RESULT_SINK_ACCUM_EN
    chk("acc_out", acc_out, m_acc);
`endif
    if (!rst_n) begin
      pend_q.delete();
      fifo_q.delete();
      m_err = 1'b0;
`ifdef XLS_TEST_RESULT_SINK_ACCUM_EN
      m_acc = '0;
`endif
    end else begin
      if (bus.in_issue && exp_ready) begin
        p.due = cyc + PL;
        p.val = x + y + z + a + c;
        pend_q.push_back(p);
      end
      if (bus.in_issue && !exp_ready) m_err = 1'b1;
      if (fifo_q.size() != 0 && bus.out_ready) begin
`ifdef XLS_TEST_RESULT_SINK_ACCUM_EN
        m_acc = acc_clear ? fifo_q[0] : m_acc + fifo_q[0];
`endif
        void'(fifo_q.pop_front());
      end
`ifdef XLS_TEST_RESULT_SINK_ACCUM_EN
      else if (acc_clear) m_acc = '0;
`endif
      if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
        p = pend_q.pop_front();
        fifo_q.push_back(p.val);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_ops(input logic [W-1:0] vx, vy, vz, va, vc);
    x = vx; y = vy; z = vz; a = va; c = vc;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    bus.in_issue = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    m_err = 1'b0;
    rst_n = 1'b0;
    bus.in_issue = 1'b0;
    bus.out_ready = 1'b1;
    set_ops('0, '0, '0, '0, '0);
`ifdef XLS_TEST_RESULT_SINK_ACCUM_EN
    acc_clear = 1'b0;
    m_acc = '0;
`endif
    @(posedge clk);
    #1;
    do_reset(2);

    // Single issue of 1+2+3+4+5, visible exactly five cycles later.
    repeat (3) step();
    set_ops(1, 2, 3, 4, 5);
    bus.in_issue = 1'b1;
    step();
    bus.in_issue = 1'b0;
    set_ops($urandom, $urandom, $urandom, $urandom, $urandom);
    repeat (4) step();
    chk("single_data", bus.out_data, 32'd15);
    chk("single_valid", W'(bus.out_valid), 32'd1);
    repeat (3) step();

    // Fill with out_ready low, then keep issuing into a closed credit.
    bus.out_ready = 1'b0;
    bus.in_issue = 1'b1;
    for (int i = 0; i < 14; i++) begin
      set_ops($urandom, $urandom, $urandom, $urandom, $urandom);
      step();
    end
    bus.in_issue = 1'b0;
    chk("fill_in_ready", W'(bus.in_ready), 32'd0);
    chk("fill_err", W'(err), 32'd1);
    repeat (4) step();
    bus.out_ready = 1'b1;
    repeat (12) step();

    // 100 back-to-back issues of z=i.
    do_reset(1);
    set_ops('0, '0, '0, '0, '0);
    bus.in_issue = 1'b1;
    for (int i = 0; i < 100; i++) begin
      z = W'(i);
      step();
    end
    bus.in_issue = 1'b0;
    repeat (8) step();

    // Reset while two results are in flight and one is queued.
    bus.out_ready = 1'b0;
    bus.in_issue = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ops($urandom, $urandom, $urandom, $urandom, $urandom);
      step();
    end
    bus.in_issue = 1'b0;
    repeat (2) step();
    do_reset(1);
    bus.out_ready = 1'b1;
    set_ops(10, 20, 30, 40, 50);
    bus.in_issue = 1'b1;
    step();
    bus.in_issue = 1'b0;
    repeat (4) step();
    chk("post_rst_data", bus.out_data, 32'd150);
    repeat (4) step();

`ifdef XLS_TEST_RESULT_SINK_ACCUM_EN
    do_reset(1);
    bus.out_ready = 1'b0;
    bus.in_issue = 1'b1;
    set_ops(32'hFFFF_FFFF, 0, 0, 0, 0);
    step();
    set_ops(2, 0, 0, 0, 0);
    step();
    bus.in_issue = 1'b0;
    repeat (5) step();
    bus.out_ready = 1'b1;
    repeat (2) step();
    chk("acc_wrap", acc_out, 32'd1);
    bus.out_ready = 1'b0;
    bus.in_issue = 1'b1;
    set_ops(7, 0, 0, 0, 0);
    step();
    bus.in_issue = 1'b0;
    repeat (5) step();
    acc_clear = 1'b1;
    bus.out_ready = 1'b1;
    step();
    acc_clear = 1'b0;
    bus.out_ready = 1'b0;
    chk("acc_clear_pop", acc_out, 32'd7);
    step();
`endif

    // Random traffic with occasional violations and resets.
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      set_ops($urandom, $urandom, $urandom, $urandom, $urandom);
      if ($urandom_range(0, 399) == 0) begin
        do_reset(1);
      end
      if (bus.in_ready) bus.in_issue = ($urandom_range(0, 3) != 0);
      else              bus.in_issue = ($urandom_range(0, 199) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0) || (i % 200 > 150);
      if ((i % 500) < 60) bus.out_ready = 1'b0;
`ifdef XLS_TEST_RESULT_SINK_ACCUM_EN
      acc_clear = ($urandom_range(0, 7) == 0);
`endif
      step();
    end
    bus.in_issue = 1'b0;
    bus.out_ready = 1'b1;
`ifdef XLS_TEST_RESULT_SINK_ACCUM_EN
    acc_clear = 1'b0;
`endif
    repeat (16) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
